// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one command byte out on device clocks, and checks the device ACK.
module ps2_host_tx #(
   parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
   parameter int unsigned INHIBIT_US       = 100,
   parameter int unsigned START_TIMEOUT_US = 15000,
   parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       err_timeout
);

   localparam int unsigned CYC_PER_US  = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned INHIBIT_CYC = INHIBIT_US * CYC_PER_US;
   localparam int unsigned START_CYC   = START_TIMEOUT_US * CYC_PER_US;
   localparam int unsigned FRAME_CYC   = FRAME_TIMEOUT_US * CYC_PER_US;
   localparam int unsigned MAX_A       = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
   localparam int unsigned MAX_CYC     = (MAX_A > FRAME_CYC) ? MAX_A : FRAME_CYC;
   localparam int          CNT_W       = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_CYC - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST   = CNT_W'(FRAME_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RTS,
      S_XFER,
      S_WAIT_IDLE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_edgeCnt;
   logic [9:0]       r_shift;
   logic             r_dataOe;
   logic             r_ack;
   logic             r_done;
   logic             r_ackOk;
   logic             r_err;
   logic [1:0]       r_clkSync;
   logic [1:0]       r_dataSync;
   logic             r_clkPrev;

   state_t           w_stateNext;
   logic [CNT_W-1:0] w_cntNext;
   logic [3:0]       w_edgeCntNext;
   logic [9:0]       w_shiftNext;
   logic             w_dataOeNext;
   logic             w_ackNext;
   logic             w_doneNext;
   logic             w_ackOkNext;
   logic             w_errNext;
   logic             w_fall;
   logic             w_timeout;

   // Synchronisers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_clkSync  <= 2'b11;
         r_dataSync <= 2'b11;
         r_clkPrev  <= 1'b1;
      end else begin
         r_clkSync  <= {r_clkSync[0], ps2_clk_in};
         r_dataSync <= {r_dataSync[0], ps2_data_in};
         r_clkPrev  <= r_clkSync[1];
      end
   end

   assign w_fall = r_clkPrev & ~r_clkSync[1];

   // Before the first device edge the start budget applies, afterwards the frame budget.
   assign w_timeout = (r_edgeCnt == 4'd0) ? (r_cnt == START_LAST) : (r_cnt == FRAME_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_edgeCnt <= 4'd0;
         r_shift   <= 10'd0;
         r_dataOe  <= 1'b0;
         r_ack     <= 1'b0;
         r_done    <= 1'b0;
         r_ackOk   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_cnt     <= w_cntNext;
         r_edgeCnt <= w_edgeCntNext;
         r_shift   <= w_shiftNext;
         r_dataOe  <= w_dataOeNext;
         r_ack     <= w_ackNext;
         r_done    <= w_doneNext;
         r_ackOk   <= w_ackOkNext;
         r_err     <= w_errNext;
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_cntNext     = r_cnt;
      w_edgeCntNext = r_edgeCnt;
      w_shiftNext   = r_shift;
      w_dataOeNext  = r_dataOe;
      w_ackNext     = r_ack;
      w_doneNext    = 1'b0;
      w_ackOkNext   = 1'b0;
      w_errNext     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cntNext = '0;
            if (tx_valid) begin
               w_shiftNext = {1'b1, ~^tx_data, tx_data};
               w_stateNext = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (r_cnt == INHIBIT_LAST) begin
               w_cntNext   = '0;
               w_stateNext = S_RTS;
            end else begin
               w_cntNext = r_cnt + 1'b1;
            end
         end
         S_RTS: begin
            w_edgeCntNext = 4'd0;
            w_dataOeNext  = 1'b1;
            w_cntNext     = r_cnt + 1'b1;
            w_stateNext   = S_XFER;
         end
         S_XFER: begin
            w_cntNext = r_cnt + 1'b1;
            if (w_timeout) begin
               w_stateNext  = S_IDLE;
               w_errNext    = 1'b1;
               w_dataOeNext = 1'b0;
               w_cntNext    = '0;
            end else if (w_fall) begin
               w_edgeCntNext = r_edgeCnt + 4'd1;
               if (r_edgeCnt == 4'd0) begin
                  w_cntNext = '0;
               end
               // The stop bit sits in the shift register, so edge 10 releases the line for free.
               if (r_edgeCnt == 4'd10) begin
                  w_ackNext    = ~r_dataSync[1];
                  w_dataOeNext = 1'b0;
                  w_stateNext  = S_WAIT_IDLE;
               end else begin
                  w_dataOeNext = ~r_shift[0];
                  w_shiftNext  = {1'b0, r_shift[9:1]};
               end
            end
         end
         S_WAIT_IDLE: begin
            w_cntNext = r_cnt + 1'b1;
            if (w_timeout) begin
               w_stateNext = S_IDLE;
               w_errNext   = 1'b1;
               w_cntNext   = '0;
            end else if (r_clkSync[1] && r_dataSync[1]) begin
               w_stateNext = S_IDLE;
               w_doneNext  = 1'b1;
               w_ackOkNext = r_ack;
               w_cntNext   = '0;
            end
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   assign tx_ready    = (r_state == S_IDLE);
   assign busy        = ~tx_ready;
   assign ps2_clk_oe  = (r_state == S_INHIBIT);
   assign ps2_data_oe = (r_state == S_RTS) | ((r_state == S_XFER) & r_dataOe);
   assign done        = r_done;
   assign ack_ok      = r_ackOk;
   assign err_timeout = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a device model clocks frames in, and
// a frame model predicts the host's data drive on every device edge.
module tb_ps2_host_tx;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int          INH    = 100;
   localparam int          START  = 15000;
   localparam int          FRAME  = 2000;
   localparam int          H      = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       err_timeout;
   logic       devClk = 1'b1;
   logic       devData = 1'b1;

   // Open-drain lines: either side may pull low.
   assign ps2_clk_in  = devClk & ~ps2_clk_oe;
   assign ps2_data_in = devData & ~ps2_data_oe;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLK_FREQ_HZ     (CLK_HZ),
      .INHIBIT_US      (100),
      .START_TIMEOUT_US(15000),
      .FRAME_TIMEOUT_US(2000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .err_timeout(err_timeout)
   );

   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         doneCount = 0;
   int         errCount = 0;
   int         inhibitLen = 0;
   int         rtsCycle = -1;
   int         errCycle = -1;
   int         edge1Cycle = -1;
   logic       lastAck = 1'b0;
   logic [9:0] capOe = 10'd0;
   logic [4:0] viol;

   // Host drive after edges 1..10: inverted data LSB first, inverted odd parity, released stop.
   function automatic logic [9:0] modelOe(input logic [7:0] b);
      logic parityBit;
      parityBit = (($countones(b) % 2) == 0);
      return {1'b0, ~parityBit, ~b};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic checkRange(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Per-cycle checker: protocol invariants, inhibit length and pulse bookkeeping.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            inhibitLen = 0;
         end else begin
            viol = {busy == tx_ready, !busy && (ps2_clk_oe || ps2_data_oe),
                    ps2_clk_oe && ps2_data_oe, done && err_timeout, ack_ok && !done};
            checkOutput("invariant", 32'(viol), 32'd0);
            if (ps2_clk_oe) begin
               inhibitLen++;
            end else if (inhibitLen != 0) begin
               checkOutput("inhibitLen", inhibitLen, INH);
               checkOutput("rtsDataOe", 32'(ps2_data_oe), 32'd1);
               rtsCycle   = cyc;
               inhibitLen = 0;
            end
            if (done) begin
               doneCount++;
               lastAck = ack_ok;
            end
            if (err_timeout) begin
               errCount++;
               errCycle = cyc;
               checkOutput("errRelease", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input bit hold);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("acceptLatency", 32'({ps2_clk_oe, busy}), 32'd3);
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic deviceRun(input int nEdges, input bit giveAck);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         if (busy && !ps2_clk_oe && ps2_data_oe) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checkOutput("rtsSeen", 32'd0, 32'd1);
         return;
      end
      checkOutput("startBitLine", 32'(ps2_data_in), 32'd0);
      repeat (20) @(negedge clk);
      for (int i = 1; i <= nEdges; i++) begin
         if (i == 11 && giveAck) devData = 1'b0;
         #1 devClk = 1'b0;
         if (i == 1) edge1Cycle = cyc;
         repeat (H) @(negedge clk);
         if (i <= 10) capOe[i-1] = ps2_data_oe;
         #1 devClk = 1'b1;
         if (i == 11) devData = 1'b1;
         repeat (H) @(negedge clk);
      end
      devClk  = 1'b1;
      devData = 1'b1;
   endtask

   task automatic waitDone(input int d0, input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (doneCount != d0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("doneWait", 32'd0, 32'd1);
   endtask

   task automatic waitErr(input int e0, input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         if (errCount != e0) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("errWait", 32'd0, 32'd1);
   endtask

   task automatic runFrame(input logic [7:0] b, input bit giveAck);
      int d0;
      int e0;
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(b, 1'b0);
      deviceRun(11, giveAck);
      waitDone(d0, 500);
      checkOutput("frameBits", 32'(capOe), 32'(modelOe(b)));
      checkOutput("doneCount", doneCount - d0, 1);
      checkOutput("ackOk", 32'(lastAck), 32'(giveAck));
      checkOutput("noErr", errCount - e0, 0);
      checkOutput("txReadyAfter", 32'(tx_ready), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int d0;
      int e0;
      logic [7:0] holdByte;

      repeat (3) @(negedge clk);
      checkOutput("rstOutputs",
                  32'({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_ok, err_timeout}),
                  32'b1000000);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("idleReady", 32'({tx_ready, busy}), 32'b10);

      // 0xF4 with ACK
      runFrame(8'hF4, 1'b1);
      checkOutput("f4Literal", 32'(capOe), 32'(10'b01_0000_1011));

      // 0xFF without ACK: parity 1 leaves the line released on edge 9
      runFrame(8'hFF, 1'b0);
      checkOutput("ffParityEdge9", 32'(capOe[8]), 32'd0);
      checkOutput("ffLiteral", 32'(capOe), 32'd0);

      // Device never clocks
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(8'h55, 1'b0);
      waitErr(e0, 20000);
      checkOutput("startTimeoutCycles", errCycle - rtsCycle, START);
      checkOutput("startNoDone", doneCount - d0, 0);
      checkOutput("startReady", 32'(tx_ready), 32'd1);

      // Device stalls after 5 edges
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(8'hA5, 1'b0);
      deviceRun(5, 1'b0);
      waitErr(e0, 3000);
      checkRange("frameTimeoutCycles", errCycle - edge1Cycle, FRAME, FRAME + 4);
      checkOutput("frameNoDone", doneCount - d0, 0);
      runFrame(8'hF4, 1'b1);

      // Asynchronous reset in the middle of a frame
      d0 = doneCount;
      e0 = errCount;
      applyStimulus(8'hF4, 1'b0);
      deviceRun(4, 1'b0);
      checkOutput("preResetDataOe", 32'(ps2_data_oe), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncReset", 32'({ps2_clk_oe, ps2_data_oe, busy, tx_ready}), 32'b0001);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("resetNoDone", doneCount - d0, 0);
      checkOutput("resetNoErr", errCount - e0, 0);
      runFrame(8'hF4, 1'b1);

      // tx_valid held through the frame while tx_data keeps changing
      d0 = doneCount;
      holdByte = 8'h3C;
      applyStimulus(holdByte, 1'b1);
      fork
         deviceRun(11, 1'b1);
         begin
            for (int k = 0; k < 3000; k++) begin
               @(negedge clk);
               if (done) break;
               tx_data = 8'($urandom);
            end
            tx_valid = 1'b0;
         end
      join
      repeat (200) @(negedge clk);
      checkOutput("holdFrameBits", 32'(capOe), 32'(modelOe(holdByte)));
      checkOutput("holdSingleFrame", doneCount - d0, 1);
      checkOutput("holdIdle", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter that sends one command byte to the mouse, e.g. 0xF4 "enable data reporting" or 0xFF "reset".
- Complements the existing PS/2 mouse receive path: it shares the PS2Clk/PS2Data open-drain lines, and the receiver ignores line activity while busy=1.
- Runs in the mouse clock domain (100 MHz).
- Performs the full protocol: clock inhibit, request-to-send, bit shifting on device-generated clocks, parity, stop bit, device ACK check and timeouts.

Parameters:
- CLK_FREQ_HZ, 100_000_000, frequency of clk in Hz.
- INHIBIT_US, 100, time ps2_clk is held low before RTS.
- START_TIMEOUT_US, 15000, maximum wait from RTS to the first device falling edge.
- FRAME_TIMEOUT_US, 2000, maximum time from the first falling edge to ACK sampled.

Ports:
- clk  in  1  module clock.
- rst_n  in  1  asynchronous active-low reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a byte is accepted on tx_valid&&tx_ready.
- ps2_clk_in  in  1  raw PS2Clk line level (asynchronous).
- ps2_data_in  in  1  raw PS2Data line level (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS2Clk low, 0 = release.
- ps2_data_oe  out  1  1 = drive PS2Data low, 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- ack_ok  out  1  valid with done: 1 = device ACKed (data low at the 11th edge).
- err_timeout  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset, asynchronous, all outputs:
  - ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_ok=0, err_timeout=0, tx_ready=1.
  - State goes to IDLE and all counters clear.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each pass through a 2-FF synchroniser.
  - A falling edge is "synced clk was 1 last cycle, 0 now".
- Framing: shift register = {1'b1 stop, parity, data[7:0]}, sent LSB first. Parity is odd: ~^tx_data.
- States and transitions:
  - IDLE: tx_ready=1, both oe=0. On accept, latch the byte and go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for INHIBIT_US×CLK_FREQ_HZ/1e6 cycles, then go to RTS.
  - RTS: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=0 in the same cycle. Clear the edge counter and go to XFER.
  - XFER:
    - Falling edges 1..9: set ps2_data_oe = ~bit[n-1] (data bits 0..7, then parity).
    - Edge 10: ps2_data_oe=0 (stop bit).
    - Edge 11: sample synced data as the ACK (low = ack_ok=1), then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk=1 and data=1, then pulse done with ack_ok, go to IDLE.
    - No ACK (data high at edge 11) still completes: done=1, ack_ok=0.
- Timeouts:
  - START_TIMEOUT runs from RTS entry until the first falling edge.
  - FRAME_TIMEOUT runs from the first edge until the WAIT_IDLE exit.
  - On expiry: release both lines in the same cycle, pulse err_timeout, no done pulse, go to IDLE.
- Simultaneous events: a timeout expiring in the same cycle as edge 11 is treated as a timeout.
- Counter width: cycle counter is $clog2 of the largest timeout in cycles; no wrap before expiry.
- tx_valid outside IDLE is ignored; the byte is not queued.
- Reset mid-frame releases both lines immediately (asynchronous); no done or err pulse.
- Latency: accept → ps2_clk_oe high on the next cycle. ACK edge → done no earlier than 1 cycle after the lines are seen idle (after the 2-cycle synchroniser).

Test Plan:
- Send 0xF4 with a device model clocking at 12.5 kHz and ACKing.
  → After the ~100 µs inhibit, data_oe on falling edges 1..9 is 1,1,0,1,0,0,0,0,1 (LSB-first bits 0,0,1,0,1,1,1,1, parity 0). Edge 10 releases the line. Expect done=1, ack_ok=1, tx_ready back to 1.
- Send 0xFF.
  → Parity bit 1 (data_oe=0 at edge 9). Model withholds the ACK → done=1, ack_ok=0.
- Device never clocks after RTS (CLK_FREQ_HZ scaled to 1 MHz for sim).
  → err_timeout pulse exactly START_TIMEOUT cycles after RTS; both oe=0; done never asserts.
- Device stops after 5 edges.
  → err_timeout after FRAME_TIMEOUT from edge 1; lines released; next tx_valid is accepted normally.
- rst_n low during XFER at edge 4.
  → ps2_clk_oe=ps2_data_oe=0 asynchronously; busy=0. After release, send 0xF4 → correct frame.
- tx_valid held high through busy with a changing tx_data.
  → Exactly one frame is sent, carrying the byte latched at accept.
